// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state type and operation encodings.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder cell, time-multiplexed by serial_add_ctrl.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one fulladder, one bit per clock,
// valid/ready request and result channels.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned    CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_MSB_IN = CW'(WIDTH - 2);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             prev_carry_q;
    logic             start_ready_q;
    logic             busy_q;
    logic             result_valid_q;
    logic             fa_sum;
    logic             fa_cout;

    fulladder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
    always_comb begin
        res_d = {fa_sum, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            res_q          <= '0;
            cnt_q          <= '0;
            carry_q        <= 1'b0;
            prev_carry_q   <= 1'b0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        a_q           <= a;
                        b_q           <= (op == OP_SUB) ? ~b : b;
                        carry_q       <= (op == OP_SUB) ? 1'b1 : cin;
                        cnt_q         <= '0;
                        state_q       <= S_RUN;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_cout;
                    if (cnt_q == CNT_MSB_IN) begin
                        prev_carry_q <= fa_cout;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_q        <= S_DONE;
                        result_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        state_q        <= S_IDLE;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        start_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    start_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready  = start_ready_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign sum          = result_valid_q ? res_q : '0;
    assign cout         = result_valid_q & carry_q;
    assign ovf          = result_valid_q & (prev_carry_q ^ carry_q);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8, 2 and 32 against an
// arithmetic reference model.
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  sv = '0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        rr = 1'b0;

    int checks = 0;
    int failures = 0;
    int sel = 0;

    logic        sr8, busy8, rv8, c8, o8;
    logic [7:0]  s8;
    logic        sr2, busy2, rv2, c2, o2;
    logic [1:0]  s2;
    logic        sr32, busy32, rv32, c32, o32;
    logic [31:0] s32;

    logic        obs_sr, obs_busy, obs_rv, obs_cout, obs_ovf;
    logic [31:0] obs_sum;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr8),
        .op(op), .a(a[7:0]), .b(b[7:0]), .cin(cin), .busy(busy8),
        .result_valid(rv8), .result_ready(rr), .sum(s8), .cout(c8), .ovf(o8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr2),
        .op(op), .a(a[1:0]), .b(b[1:0]), .cin(cin), .busy(busy2),
        .result_valid(rv2), .result_ready(rr), .sum(s2), .cout(c2), .ovf(o2)
    );

    serial_add_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr32),
        .op(op), .a(a), .b(b), .cin(cin), .busy(busy32),
        .result_valid(rv32), .result_ready(rr), .sum(s32), .cout(c32), .ovf(o32)
    );

    always_comb begin
        obs_sr   = sr8;
        obs_busy = busy8;
        obs_rv   = rv8;
        obs_sum  = 32'(s8);
        obs_cout = c8;
        obs_ovf  = o8;
        case (sel)
            1: begin
                obs_sr = sr2; obs_busy = busy2; obs_rv = rv2;
                obs_sum = 32'(s2); obs_cout = c2; obs_ovf = o2;
            end
            2: begin
                obs_sr = sr32; obs_busy = busy32; obs_rv = rv32;
                obs_sum = s32; obs_cout = c32; obs_ovf = o32;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s w_sel=%0d observed=%h expected=%h", tag, sel, obs, exp);
        end
    endtask

    // Signed/unsigned integer arithmetic on w-bit values: returns {ovf, cout, sum}.
    function automatic logic [33:0] ref_model(input int w, input logic o,
                                              input logic [31:0] av, input logic [31:0] bv,
                                              input logic ci);
        longint m, ua, ub, t, sa, sb, r, hi, lo;
        logic   v, c;
        m  = (longint'(1) << w) - 1;
        ua = longint'(av) & m;
        ub = longint'(bv) & m;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        sa = (ua > hi) ? ua - (longint'(1) << w) : ua;
        sb = (ub > hi) ? ub - (longint'(1) << w) : ub;
        if (o) begin
            t = ua + ((~ub) & m) + 1;
            r = sa - sb;
        end else begin
            t = ua + ub + longint'(ci);
            r = sa + sb + longint'(ci);
        end
        v = (r > hi) || (r < lo);
        c = ((t >> w) & 1) != 0;
        return {v, c, 32'(t & m)};
    endfunction

    task automatic do_op(input int s, input int w, input logic o,
                         input logic [31:0] av, input logic [31:0] bv, input logic ci,
                         input int stall, input logic [31:0] es, input logic ec, input logic eo);
        sel = s;
        @(posedge clk); #1;
        chk("start_ready_idle", 32'(obs_sr), 32'd1);
        a = av; b = bv; op = o; cin = ci; rr = 1'b0;
        sv = '0; sv[s] = 1'b1;
        @(posedge clk); #1;
        sv = '0;
        chk("busy_after_accept", 32'(obs_busy), 32'd1);
        chk("start_ready_run", 32'(obs_sr), 32'd0);
        for (int i = 1; i < w; i++) begin
            @(posedge clk); #1;
            chk("result_valid_early", 32'(obs_rv), 32'd0);
            chk("sum_gated_run", obs_sum, 32'd0);
        end
        @(posedge clk); #1;
        chk("result_valid_latency", 32'(obs_rv), 32'd1);
        chk("sum", obs_sum, es);
        chk("cout", 32'(obs_cout), 32'(ec));
        chk("ovf", 32'(obs_ovf), 32'(eo));
        for (int i = 0; i < stall; i++) begin
            a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1)); cin = 1'b1;
            sv[s] = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", 32'(obs_rv), 32'd1);
            chk("stall_start_ready", 32'(obs_sr), 32'd0);
            chk("stall_sum", obs_sum, es);
            chk("stall_cout", 32'(obs_cout), 32'(ec));
            chk("stall_ovf", 32'(obs_ovf), 32'(eo));
        end
        sv = '0;
        rr = 1'b1;
        @(posedge clk); #1;
        rr = 1'b0;
        chk("valid_drop", 32'(obs_rv), 32'd0);
        chk("start_ready_back", 32'(obs_sr), 32'd1);
        chk("busy_drop", 32'(obs_busy), 32'd0);
        chk("sum_gated_idle", obs_sum, 32'd0);
    endtask

    task automatic rand_op(input int s, input int w, input logic o,
                           input logic [31:0] av, input logic [31:0] bv, input logic ci,
                           input int stall);
        logic [33:0] e;
        e = ref_model(w, o, av, bv, ci);
        do_op(s, w, o, av, bv, ci, stall, e[31:0], e[32], e[33]);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_start_ready"}, 32'(obs_sr), 32'd1);
        chk({tag, "_busy"}, 32'(obs_busy), 32'd0);
        chk({tag, "_result_valid"}, 32'(obs_rv), 32'd0);
        chk({tag, "_sum"}, obs_sum, 32'd0);
        chk({tag, "_cout"}, 32'(obs_cout), 32'd0);
        chk({tag, "_ovf"}, 32'(obs_ovf), 32'd0);
    endtask

    initial begin
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_reset_state("reset");
        end
        rst_n = 1'b1;

        // Directed WIDTH=8 arithmetic
        do_op(0, 8, 1'b0, 32'h3C, 32'h25, 1'b0, 0, 32'h61, 1'b0, 1'b0);
        do_op(0, 8, 1'b0, 32'hFF, 32'h01, 1'b0, 0, 32'h00, 1'b1, 1'b0);
        do_op(0, 8, 1'b0, 32'h7F, 32'h01, 1'b0, 0, 32'h80, 1'b0, 1'b1);
        do_op(0, 8, 1'b0, 32'h10, 32'h20, 1'b1, 0, 32'h31, 1'b0, 1'b0);
        do_op(0, 8, 1'b1, 32'h05, 32'h07, 1'b1, 0, 32'hFE, 1'b0, 1'b0);
        do_op(0, 8, 1'b1, 32'h80, 32'h01, 1'b0, 0, 32'h7F, 1'b1, 1'b1);
        do_op(0, 8, 1'b1, 32'h09, 32'h09, 1'b0, 0, 32'h00, 1'b1, 1'b0);

        // Backpressure with ignored start pulses, then a normal op
        do_op(0, 8, 1'b0, 32'h7F, 32'h01, 1'b0, 5, 32'h80, 1'b0, 1'b1);
        do_op(0, 8, 1'b1, 32'h80, 32'h01, 1'b0, 0, 32'h7F, 1'b1, 1'b1);

        // Asynchronous reset after 3 bits of RUN
        sel = 0;
        @(posedge clk); #1;
        a = 32'hFF; b = 32'hFF; op = 1'b0; cin = 1'b1; sv[0] = 1'b1;
        @(posedge clk); #1;
        sv = '0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk_reset_state("after_release");
        do_op(0, 8, 1'b0, 32'hAA, 32'h55, 1'b0, 0, 32'hFF, 1'b0, 1'b0);

        // WIDTH=2 corners and random
        rand_op(1, 2, 1'b0, 32'h1, 32'h1, 1'b0, 0);
        rand_op(1, 2, 1'b1, 32'h2, 32'h1, 1'b0, 1);
        rand_op(1, 2, 1'b0, 32'h3, 32'h3, 1'b1, 2);
        for (int i = 0; i < 30; i++) begin
            rand_op(1, 2, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // WIDTH=32 corners and random
        rand_op(2, 32, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 0);
        rand_op(2, 32, 1'b1, 32'h8000_0000, 32'h1, 1'b0, 1);
        rand_op(2, 32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        for (int i = 0; i < 30; i++) begin
            rand_op(2, 32, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add/subtract controller. It time-multiplexes one fulladder cell across WIDTH-bit operands, processing one bit per clock with a registered carry. It accepts operations on a valid/ready request channel and returns sum, carry-out and signed overflow on a valid/ready result channel. It is the area-minimal alternative to the parallel ripple and carry-skip adders in the arithmetic library.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request valid
start_ready  output  1  request accepted when start_valid & start_ready at clk edge
op  input  1  0 = add, 1 = subtract (a - b)
a  input  WIDTH  operand A, sampled at accept
b  input  WIDTH  operand B, sampled at accept
cin  input  1  carry-in for add; ignored for subtract
busy  output  1  high in RUN or DONE
result_valid  output  1  result available
result_ready  input  1  result consumed when result_valid & result_ready at clk edge
sum  output  WIDTH  result bits
cout  output  1  add: carry out; subtract: NOT borrow (1 when a >= b unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n asynchronous assert, active low; internal flops use async clear.
  - Reset values: state=IDLE, start_ready=1 (combinational from IDLE), busy=0, result_valid=0, sum=0, cout=0, ovf=0, counter=0, carry=0.
- States: IDLE, RUN, DONE.
  - start_ready = (state==IDLE).
  - busy = (state!=IDLE).
  - result_valid = (state==DONE).
- IDLE:
  - On start_valid & start_ready: load a into shift reg A.
  - Load b into shift reg B, or ~b if op=1.
  - Carry reg = cin for add, 1 for subtract.
  - Bit counter = 0; go to RUN.
- RUN, one bit per cycle:
  - The fulladder gets A[0], B[0], carry.
  - Its sum bit shifts into the result reg from the MSB side. A and B shift right.
  - Carry reg takes the fulladder carry output.
  - When counter == WIDTH-2 is processed, latch the carry into prev_carry (carry into the MSB).
  - When counter == WIDTH-1 is processed, go to DONE.
  - Otherwise increment the counter. Counter width is $clog2(WIDTH).
- DONE:
  - cout = final carry; ovf = prev_carry XOR final carry.
  - sum/cout/ovf are held stable while result_valid=1 and result_ready=0.
  - On result_valid & result_ready, go to IDLE.
- Latency and throughput:
  - Accept at edge k; result_valid is high after edge k+WIDTH.
  - Minimum throughput is one op per WIDTH+2 cycles.
  - There is no overlap: start_ready is low in DONE even if result_ready is high that cycle.
- Output gating: sum, cout and ovf are driven 0 whenever result_valid=0.
- start_valid while busy is ignored. Inputs are not sampled and there is no error.
- result_ready outside DONE is ignored.
- Reset mid-operation (RUN or DONE) aborts immediately. All state returns to reset values and the partial result is discarded.
- Arithmetic matches a parallel WIDTH-bit adder:
  - add: {cout,sum} = a + b + cin.
  - sub: {cout,sum} = a + ~b + 1.

Decomposition:
- Shared header (serial_add_defs.vh) holds:
  - state encodings: localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - op encodings: OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: the existing fulladder cell, instantiated once for the bit datapath.
- Shift registers, counter and FSM stay in serial_add_ctrl.

Test Plan:
1. WIDTH=8, add a=8'h3C b=8'h25 cin=0, result_ready=1.
   - Response: sum=8'h61, cout=0, ovf=0.
   - result_valid rises exactly 8 cycles after the accept edge and lasts 1 cycle; start_ready returns the next cycle.
2. Add 8'hFF+8'h01 cin=0 -> sum=8'h00 cout=1 ovf=0. Add 8'h7F+8'h01 -> sum=8'h80 cout=0 ovf=1. Add 8'h10+8'h20 cin=1 -> sum=8'h31.
3. Sub 8'h05-8'h07 -> sum=8'hFE cout=0 ovf=0. Sub 8'h80-8'h01 -> sum=8'h7F cout=1 ovf=1. Sub 8'h09-8'h09 -> sum=8'h00 cout=1.
4. Backpressure: hold result_ready=0 for 5 cycles in DONE.
   - sum/cout/ovf stay stable; start_ready=0; start_valid pulses with other operands are ignored.
   - result_ready=1 -> IDLE next cycle; the following op still computes correctly.
5. Assert rst_n=0 asynchronously mid-RUN, after 3 bits.
   - Outputs go to reset values with no clock edge needed; busy=0.
   - After release, a=8'hAA+b=8'h55 gives sum=8'hFF cout=0 with no residue from the aborted op.
6. Instantiate WIDTH=2 and WIDTH=32.
   - Randomized add/sub with random result_ready stalls, checked against a reference model.
   - Verify latency = WIDTH cycles and that ovf is correct at both widths.
